key_pio_irq: RTL and testbench

- Parametrised Avalon-MM slave for push-button or switch inputs.
- Input path per bit: synchroniser, debounce, edge capture into sticky per-bit flags, interrupt mask, level IRQ output.
- Sits between board keys and the Qsys interconnect. Host CPU polls the debounced state or takes an interrupt on key press.
- Register map is the classic PIO layout: data, direction slot, irqmask, edgecapture.

---
 rtl/key_pio_pkg.sv | 27 ++
 rtl/key_debounce.sv | 54 +++++
 rtl/key_pio_irq.sv | 86 ++++++++
 tb/tb_key_pio_irq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pio_pkg.sv
// Shared constants for the key PIO: register addresses, capture-edge encodings, bus width.
package key_pio_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } key_pio_addr_e;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic capture_hit(input logic cur, input logic prev, input int mode);
    logic hit;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_ANY:  hit = cur ^ prev;
      default:   hit = ~cur & prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One input bit: synchroniser chain followed by an optional hold-time debouncer.
// Debounce counter is built only when KEY_PIO_DEBOUNCE_EN is defined; otherwise deb = sync.
module key_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic deb
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_reg[SYNC_STAGES-1];

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             deb_reg;

  // Any return to the accepted level restarts the hold count, so short glitches never land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      deb_reg <= IDLE_LEVEL;
    end else if (sync == deb_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      deb_reg <= sync;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign deb = deb_reg;
`else
  assign deb = sync;
`endif

endmodule

// File: rtl/key_pio_irq.sv
// Avalon-MM key/switch PIO with sticky edge capture and masked level IRQ.
// Debounce counters are present only when KEY_PIO_DEBOUNCE_EN is defined.
module key_pio_irq
  import key_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1,
  parameter int   CAPTURE_EDGE    = EDGE_FALL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0]  deb;
  logic [WIDTH-1:0]  deb_q_reg;
  logic [WIDTH-1:0]  edge_hit;
  logic [WIDTH-1:0]  irqmask_reg;
  logic [WIDTH-1:0]  edgecap_reg;
  logic [WIDTH-1:0]  edgecap_clr;
  logic [DATA_W-1:0] readdata_reg;
  logic [DATA_W-1:0] read_next;
  logic              wr_en;
  logic              unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      key_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (in_port[gi]),
        .deb    (deb[gi])
      );
      assign edge_hit[gi] = capture_hit(deb[gi], deb_q_reg[gi], CAPTURE_EDGE);
    end
  endgenerate

  assign edgecap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed in after the clear so a same-cycle capture survives the write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q_reg    <= {WIDTH{IDLE_LEVEL}};
      irqmask_reg  <= '0;
      edgecap_reg  <= '0;
      readdata_reg <= '0;
    end else begin
      deb_q_reg    <= deb;
      edgecap_reg  <= (edgecap_reg & ~edgecap_clr) | edge_hit;
      readdata_reg <= read_next;
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    read_next = '0;
    case (address)
      ADDR_DATA:    read_next[WIDTH-1:0] = deb;
      ADDR_IRQMASK: read_next[WIDTH-1:0] = irqmask_reg;
      ADDR_EDGECAP: read_next[WIDTH-1:0] = edgecap_reg;
      default:      read_next = '0;
    endcase
  end

  assign readdata = readdata_reg;
  assign irq      = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_key_pio_irq.sv
// Self-checking bench for key_pio_irq; expectations adapt to whether KEY_PIO_DEBOUNCE_EN is defined.
module tb_key_pio_irq;

  localparam int WIDTH = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int LAT       = 6;
  localparam bit DEB_BUILT = 1'b1;
`else
  localparam int LAT       = 2;
  localparam bit DEB_BUILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = 4'hF;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic        irq_q[$];

  key_pio_irq #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .IDLE_LEVEL     (1'b1),
    .CAPTURE_EDGE   (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    logic [31:0] got;
    repeat (3) tick();
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_err++; $display("FAIL reset_readdata: got 0x%08h expected 0x00000000", readdata);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    reset_n = 1'b1;
    exp_q.push_back(32'h0000000F);
    tick();
    got = readdata; exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_data_read: got 0x%08h expected 0x%08h", got, exp);
    end
    for (int a = 1; a < 4; a++) begin
      address = 2'(a);
      exp_q.push_back(32'h0);
      tick();
      got = readdata; exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL reset_read_addr%0d: got 0x%08h expected 0x%08h", a, got, exp);
      end
    end
    $display("reset: data/dir/irqmask/edgecap read, irq=%b", irq);
  endtask

  task automatic test_irqmask_rw();
    logic [31:0] exp;
    logic [31:0] wvals [2];
    wvals[0] = 32'hFFFF_FFFF;
    wvals[1] = 32'h0000_0002;
    for (int i = 0; i < 2; i++) begin
      bus_write(2'd2, wvals[i]);
      exp_q.push_back(wvals[i] & 32'hF);
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if (readdata !== exp) begin
        n_err++; $display("FAIL irqmask_readback: got 0x%08h expected 0x%08h", readdata, exp);
      end
      $display("irqmask write 0x%08h -> read 0x%08h", wvals[i], readdata);
    end
  endtask

  task automatic test_press();
    logic [31:0] exp;
    logic        exp_irq;
    address = 2'd0;
    tick();
    in_port[1] = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      exp_q.push_back(k <= LAT ? 32'hF : 32'hD);
      irq_q.push_back(k <= LAT ? 1'b0 : 1'b1);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      exp = exp_q.pop_front(); exp_irq = irq_q.pop_front();
      n_cmp++;
      if (readdata !== exp) begin
        n_err++; $display("FAIL press_data_edge%0d: got 0x%08h expected 0x%08h", k, readdata, exp);
      end
      n_cmp++;
      if (irq !== exp_irq) begin
        n_err++; $display("FAIL press_irq_edge%0d: got %b expected %b", k, irq, exp_irq);
      end
    end
    address = 2'd3;
    exp_q.push_back(32'h2);
    tick();
    exp = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp) begin
      n_err++; $display("FAIL press_edgecap: got 0x%08h expected 0x%08h", readdata, exp);
    end
    $display("press key1: data latency %0d edges, edgecap=0x%08h irq=%b", LAT, readdata, irq);
  endtask

  task automatic test_clear();
    logic [31:0] exp;
    bus_write(2'd3, 32'h0);
    exp_q.push_back(32'h2);
    tick();
    exp = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp || irq !== 1'b1) begin
      n_err++; $display("FAIL clear_write0: got edgecap 0x%08h irq %b expected 0x%08h irq 1", readdata, irq, exp);
    end
    bus_write(2'd3, 32'h2);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL clear_irq_fall: got %b expected 0", irq);
    end
    exp_q.push_back(32'h0);
    tick();
    exp = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp) begin
      n_err++; $display("FAIL clear_edgecap: got 0x%08h expected 0x%08h", readdata, exp);
    end
    $display("write-1-clear edgecap: edgecap=0x%08h irq=%b", readdata, irq);
  endtask

  task automatic test_glitch();
    logic [31:0] exp;
    logic [31:0] exp_cap;
    int          bad;
    address = 2'd0;
    tick();
    in_port[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      // Without debounce the 3-cycle pulse reaches deb after edges 2..4, readdata after 3..5.
      exp_q.push_back((!DEB_BUILT && k >= 3 && k <= 5) ? 32'hC : 32'hD);
    end
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) in_port[0] = 1'b1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (readdata !== exp) begin
        n_err++; bad++;
        $display("FAIL glitch_data_edge%0d: got 0x%08h expected 0x%08h", k, readdata, exp);
      end
    end
    exp_cap = DEB_BUILT ? 32'h0 : 32'h1;
    address = 2'd3;
    tick();
    n_cmp++;
    if (readdata !== exp_cap || irq !== 1'b0) begin
      n_err++; $display("FAIL glitch_edgecap: got 0x%08h irq %b expected 0x%08h irq 0", readdata, irq, exp_cap);
    end
    bus_write(2'd3, 32'hF);
    $display("glitch key0 3 cycles: edgecap=0x%08h irq=%b (%0d data errors)", readdata, irq, bad);
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    bus_write(2'd2, 32'h4);
    in_port[2] = 1'b0;
    repeat (LAT) tick();
    address    = 2'd3;
    writedata  = 32'h4;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_irq: got %b expected 1", irq);
    end
    exp_q.push_back(32'h4);
    tick();
    exp = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp) begin
      n_err++; $display("FAIL same_cycle_edgecap: got 0x%08h expected 0x%08h", readdata, exp);
    end
    $display("set vs clear same cycle: edgecap=0x%08h irq=%b", readdata, irq);
    bus_write(2'd3, 32'h4);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_later_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_key3();
    logic [31:0] exp;
    in_port = 4'hF;
    repeat (LAT + 3) tick();
    bus_write(2'd3, 32'hF);
    address = 2'd0;
    tick();
    in_port[3] = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) exp_q.push_back(k <= LAT ? 32'hF : 32'h7);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if (readdata !== exp) begin
        n_err++; $display("FAIL key3_hold_edge%0d: got 0x%08h expected 0x%08h", k, readdata, exp);
      end
    end
    address = 2'd3;
    tick();
    n_cmp++;
    if (readdata !== 32'h8) begin
      n_err++; $display("FAIL key3_hold_edgecap: got 0x%08h expected 0x00000008", readdata);
    end
    $display("hold key3: data=0x7 after %0d edges, edgecap=0x%08h", LAT, readdata);
    in_port[3] = 1'b1;
    repeat (LAT + 3) tick();
    bus_write(2'd3, 32'hF);
    in_port[3] = 1'b0;
    tick();
    in_port[3] = 1'b1;
    exp_q.push_back(DEB_BUILT ? 32'h0 : 32'h8);
    repeat (LAT + 3) tick();
    exp = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp) begin
      n_err++; $display("FAIL key3_pulse_edgecap: got 0x%08h expected 0x%08h", readdata, exp);
    end
    $display("1-cycle pulse key3: edgecap=0x%08h", readdata);
  endtask

  initial begin
    test_reset();
    test_irqmask_rw();
    test_press();
    test_clear();
    test_glitch();
    test_same_cycle();
    test_key3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
